// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: accepts a job length, streams operand pairs into one
// mac instance, waits out the mac latency and hands off the accumulated result.
module mac_dot_ctrl #(
  parameter int D_W     = 32,
  parameter int D_W_ACC = 32,
  parameter int LEN_W   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [LEN_W-1:0]   start_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_W-1:0]     in_a,
  input  logic [D_W-1:0]     in_b,
  output logic               mac_enable,
  output logic               mac_initialize,
  output logic [D_W-1:0]     mac_a,
  output logic [D_W-1:0]     mac_b,
  input  logic [D_W_ACC-1:0] mac_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_W_ACC-1:0] out_data,
  output logic               busy
);

  localparam int CNT_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    OUT
  } state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   remaining;
  logic [CNT_W-1:0]   drain_cnt;
  logic               first_beat;
  logic               fire;

  always_comb begin
    state_nxt      = state;
    start_ready    = 1'b0;
    in_ready       = 1'b0;
    fire           = 1'b0;
    mac_enable     = 1'b0;
    mac_initialize = 1'b0;
    mac_a          = '0;
    mac_b          = '0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid)
          state_nxt = (start_len != '0) ? STREAM : OUT;
      end
      STREAM: begin
        in_ready       = 1'b1;
        mac_a          = in_a;
        mac_b          = in_b;
        fire           = in_valid;
        mac_enable     = fire;
        mac_initialize = fire & first_beat;
        if (fire && remaining == LEN_W'(1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == CNT_W'(1))
          state_nxt = OUT;
      end
      OUT: begin
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      remaining  <= '0;
      drain_cnt  <= '0;
      out_data   <= '0;
      first_beat <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_valid) begin
            remaining  <= start_len;
            first_beat <= 1'b1;
            // zero-length job skips the mac entirely and reports zero
            if (start_len == '0)
              out_data <= '0;
          end
        end
        STREAM: begin
          if (fire) begin
            remaining  <= remaining - LEN_W'(1);
            first_beat <= 1'b0;
            if (remaining == LEN_W'(1))
              drain_cnt <= CNT_W'(MAC_LAT);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - CNT_W'(1);
          if (drain_cnt == CNT_W'(1))
            out_data <= mac_result;
        end
        default: ;
      endcase
    end
  end

endmodule
